// File: rtl/vector_shift_unit_if.sv
// Operand/result bundle for vector_shift_unit.
// Defining VSHIFT_VL_EN adds the vl signal for tail-undisturbed element masking.
interface vector_shift_unit_if #(
  parameter int VLEN = 512
);
  logic                   shift_en;
  logic [VLEN-1:0]        data1;
  logic [VLEN-1:0]        data2;
  logic [1:0]             op_type;
  logic [2:0]             shift_op;
  logic [6:0]             sew;
`ifdef VSHIFT_VL_EN
  logic [$clog2(VLEN):0]  vl;
`endif
  logic [VLEN-1:0]        shift_result;
  logic                   shift_done;

  modport master (
`ifdef VSHIFT_VL_EN
    output vl,
`endif
    output shift_en, data1, data2, op_type, shift_op, sew,
    input  shift_result, shift_done
  );

  modport slave (
`ifdef VSHIFT_VL_EN
    input  vl,
`endif
    input  shift_en, data1, data2, op_type, shift_op, sew,
    output shift_result, shift_done
  );
endinterface

// File: rtl/vector_shift_unit.sv
// Element-wise SLL/SRL/SRA over SEW 8/16/32 lanes with a one-cycle registered result.
// Optional feature macro VSHIFT_VL_EN: elements at index >= vl pass data2 through unchanged.
module vector_shift_unit #(
  parameter int VLEN = 512,
  parameter int ELEN = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  vector_shift_unit_if.slave  bus
);

  localparam int N8  = VLEN / 8;
  localparam int N16 = VLEN / 16;
  localparam int N32 = VLEN / 32;
`ifdef VSHIFT_VL_EN
  localparam int VL_W = $clog2(VLEN) + 1;
`endif

  logic [VLEN-1:0] res8, res16, res32;
  logic [VLEN-1:0] result_raw;
  logic            legal_op;
  logic [VLEN-1:0] shift_result_d, shift_result_q;
  logic            shift_done_d, shift_done_q;

  // One lane of width w held zero-extended in 32 bits; the amount is masked to log2(w) bits here.
  function automatic logic [31:0] shift_elem(input logic [31:0] a, input logic [31:0] amt,
                                             input logic [2:0] op, input int w);
    logic [31:0] mask;
    logic [31:0] sh;
    logic [31:0] a_sext;
    logic [31:0] r;
    mask   = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    sh     = amt & 32'(w - 1);
    a_sext = a[w-1] ? (a | ~mask) : a;
    case (op)
      3'b000:  r = a << sh;
      3'b001:  r = a >> sh;
      3'b010:  r = 32'($signed(a_sext) >>> sh);
      default: r = 32'd0;
    endcase
    return r & mask;
  endfunction

  always_comb begin
    res8  = '0;
    res16 = '0;
    res32 = '0;
    for (int i = 0; i < N8; i++) begin
      res8[i*8 +: 8] = 8'(shift_elem(32'(bus.data2[i*8 +: 8]),
                         (bus.op_type == 2'b00) ? 32'(bus.data1[i*8 +: 8]) : 32'(bus.data1[7:0]),
                         bus.shift_op, 8));
`ifdef VSHIFT_VL_EN
      if (VL_W'(i) >= bus.vl) res8[i*8 +: 8] = bus.data2[i*8 +: 8];
`endif
    end
    for (int i = 0; i < N16; i++) begin
      res16[i*16 +: 16] = 16'(shift_elem(32'(bus.data2[i*16 +: 16]),
                           (bus.op_type == 2'b00) ? 32'(bus.data1[i*16 +: 16]) : 32'(bus.data1[15:0]),
                           bus.shift_op, 16));
`ifdef VSHIFT_VL_EN
      if (VL_W'(i) >= bus.vl) res16[i*16 +: 16] = bus.data2[i*16 +: 16];
`endif
    end
    for (int i = 0; i < N32; i++) begin
      res32[i*32 +: 32] = shift_elem(bus.data2[i*32 +: 32],
                           (bus.op_type == 2'b00) ? bus.data1[i*32 +: 32] : bus.data1[31:0],
                           bus.shift_op, 32);
`ifdef VSHIFT_VL_EN
      if (VL_W'(i) >= bus.vl) res32[i*32 +: 32] = bus.data2[i*32 +: 32];
`endif
    end
  end

  // Reserved encodings and illegal widths still complete, just with an all-zero result.
  always_comb begin
    legal_op   = (bus.op_type != 2'b11) && (bus.shift_op <= 3'd2);
    result_raw = '0;
    case (bus.sew)
      7'd8:    result_raw = res8;
      7'd16:   result_raw = res16;
      7'd32:   result_raw = (ELEN >= 32) ? res32 : '0;
      default: result_raw = '0;
    endcase
    if (!legal_op) result_raw = '0;
    shift_result_d = bus.shift_en ? result_raw : shift_result_q;
    shift_done_d   = bus.shift_en;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_result_q <= '0;
      shift_done_q   <= 1'b0;
    end else begin
      shift_result_q <= shift_result_d;
      shift_done_q   <= shift_done_d;
    end
  end

  assign bus.shift_result = shift_result_q;
  assign bus.shift_done   = shift_done_q;

endmodule

// File: tb/tb_vector_shift_unit.sv
// Scoreboard bench for vector_shift_unit: stimulus pushes expected results, a monitor pops and compares.
// Honours VSHIFT_VL_EN by driving vl and modelling tail-undisturbed elements.
module tb_vector_shift_unit;

  localparam int VLEN = 512;
  localparam int ELEN = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vector_shift_unit_if #(.VLEN(VLEN)) bus();

  vector_shift_unit #(.VLEN(VLEN), .ELEN(ELEN)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int testsRun    = 0;
  int testsFailed = 0;
  bit monitorOn   = 1'b0;
  logic [VLEN-1:0] expQ[$];
  logic [VLEN-1:0] heldExp = '0;

  task automatic checkOutput(input string name, input logic [VLEN-1:0] actual,
                             input logic [VLEN-1:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s got=%0h want=%0h", name, actual, expected);
    end
  endtask

  // Reference: each lane treated as an integer; shifts done as multiply/divide by powers of two.
  function automatic logic [VLEN-1:0] refModel(input logic [VLEN-1:0] d1, input logic [VLEN-1:0] d2,
                                               input logic [1:0] opt, input logic [2:0] sop,
                                               input logic [6:0] sw, input int vlm);
    logic [VLEN-1:0] res, tmp, part;
    longint base, half, a, amt, p, s, r;
    int w, n, sh;
    res = '0;
    w = int'(sw);
    if (opt == 2'd3 || sop > 3'd2 || !(w == 8 || w == 16 || w == 32)) return res;
    n    = VLEN / w;
    base = longint'(1) << w;
    half = base / 2;
    for (int i = 0; i < n; i++) begin
      tmp = d2 >> (i * w);
      a   = longint'({32'd0, tmp[31:0]}) % base;
      if (i >= vlm) begin
        r = a;
      end else begin
        if (opt == 2'd0) begin
          tmp = d1 >> (i * w);
          amt = longint'({32'd0, tmp[31:0]}) % base;
        end else if (opt == 2'd1) begin
          amt = longint'({32'd0, d1[31:0]}) % base;
        end else begin
          amt = longint'(d1[4:0]);
        end
        sh = int'(amt % w);
        p  = longint'(1) << sh;
        if (sop == 3'd0) begin
          r = (a % (base / p)) * p;
        end else if (sop == 3'd1) begin
          r = a / p;
        end else begin
          s = (a >= half) ? a - base : a;
          r = (s >= 0) ? s / p : -((-s + p - 1) / p);
          if (r < 0) r = r + base;
        end
      end
      part = '0;
      part[63:0] = 64'(r);
      res = res | (part << (i * w));
    end
    return res;
  endfunction

  function automatic logic [VLEN-1:0] randVec();
    logic [VLEN-1:0] v;
    for (int k = 0; k < VLEN / 32; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic applyStimulus(input logic [VLEN-1:0] d1, input logic [VLEN-1:0] d2,
                               input logic [1:0] opt, input logic [2:0] sop, input logic [6:0] sw,
                               input int vlv, input logic [VLEN-1:0] expected);
    @(negedge clk);
    bus.shift_en = 1'b1;
    bus.data1    = d1;
    bus.data2    = d2;
    bus.op_type  = opt;
    bus.shift_op = sop;
    bus.sew      = sw;
`ifdef VSHIFT_VL_EN
    bus.vl       = ($clog2(VLEN)+1)'(vlv);
`endif
    expQ.push_back(expected);
  endtask

  task automatic applyModelled(input logic [VLEN-1:0] d1, input logic [VLEN-1:0] d2,
                               input logic [1:0] opt, input logic [2:0] sop, input logic [6:0] sw,
                               input int vlv);
    applyStimulus(d1, d2, opt, sop, sw, vlv, refModel(d1, d2, opt, sop, sw, vlv));
  endtask

  task automatic idle(input int cycles);
    repeat (cycles) begin
      @(negedge clk);
      bus.shift_en = 1'b0;
    end
  endtask

  // Monitor: a done pulse consumes one expectation; otherwise the last result must hold.
  always @(negedge clk) begin
    if (rst_n && monitorOn) begin
      if (bus.shift_done) begin
        if (expQ.size() == 0) begin
          checkOutput("spurious_done", VLEN'(bus.shift_done), '0);
        end else begin
          heldExp = expQ.pop_front();
          checkOutput("result", bus.shift_result, heldExp);
        end
      end else begin
        checkOutput("hold", bus.shift_result, heldExp);
      end
    end
  end

  initial begin
    logic [VLEN-1:0] d1, d2;
    logic [1:0] opt;
    logic [2:0] sop;
    logic [6:0] sw;
    int vlv, pick;

    bus.shift_en = 1'b0;
    bus.data1    = '0;
    bus.data2    = '0;
    bus.op_type  = '0;
    bus.shift_op = '0;
    bus.sew      = 7'd8;
`ifdef VSHIFT_VL_EN
    bus.vl       = '0;
`endif
    repeat (2) @(negedge clk);
    checkOutput("reset_result", bus.shift_result, '0);
    checkOutput("reset_done", VLEN'(bus.shift_done), '0);
    rst_n = 1'b1;
    monitorOn = 1'b1;

    applyStimulus(VLEN'(16'h0201), VLEN'(16'h140A), 2'd0, 3'd0, 7'd8, VLEN, VLEN'(16'h5014));
    applyStimulus(VLEN'(8'd2), VLEN'(16'h140A), 2'd1, 3'd1, 7'd8, VLEN, VLEN'(16'h0502));
    applyStimulus(VLEN'(5'd3), VLEN'(48'h8000_0080_0040), 2'd2, 3'd2, 7'd16, VLEN,
                  VLEN'(48'hF000_0010_0008));
    applyStimulus(VLEN'(3), VLEN'(5), 2'd0, 3'd0, 7'd32, VLEN, VLEN'(40));
    applyStimulus(VLEN'(9), VLEN'(8'h81), 2'd1, 3'd0, 7'd8, VLEN, VLEN'(8'h02));
    idle(2);
    applyStimulus(VLEN'(1), {VLEN{1'b1}}, 2'd0, 3'd7, 7'd8, VLEN, '0);
    applyStimulus(VLEN'(1), {VLEN{1'b1}}, 2'd3, 3'd0, 7'd8, VLEN, '0);
    applyStimulus(VLEN'(1), {VLEN{1'b1}}, 2'd0, 3'd0, 7'd12, VLEN, '0);
    idle(1);

    for (int k = 0; k < 3; k++) applyModelled(randVec(), randVec(), 2'd0, 3'(k), 7'd16, VLEN);
    idle(3);

    applyStimulus(VLEN'(2), VLEN'(8'h11), 2'd1, 3'd0, 7'd8, VLEN, VLEN'(8'h44));
    @(posedge clk);
    #1;
    bus.shift_en = 1'b0;
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_result", bus.shift_result, '0);
    checkOutput("midreset_done", VLEN'(bus.shift_done), '0);
    expQ.delete();
    heldExp = '0;
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);

`ifdef VSHIFT_VL_EN
    applyModelled(randVec(), randVec(), 2'd0, 3'd0, 7'd32, 2);
    applyModelled(randVec(), randVec(), 2'd1, 3'd2, 7'd8, 0);
    idle(1);
`endif

    for (int t = 0; t < 200; t++) begin
      pick = $urandom_range(0, 19);
      sw   = (pick < 6) ? 7'd8 : (pick < 12) ? 7'd16 : (pick < 19) ? 7'd32 : 7'(pick);
      opt  = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      sop  = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      d1   = randVec();
      d2   = randVec();
      vlv  = VLEN;
`ifdef VSHIFT_VL_EN
      vlv  = $urandom_range(0, VLEN / 8 + 2);
`endif
      applyModelled(d1, d2, opt, sop, sw, vlv);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
    end

    idle(4);
    checkOutput("drain", VLEN'(expQ.size()), '0);
    monitorOn = 1'b0;
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
